// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// default parameter values.
package rst_pkg;

   typedef enum logic [1:0] {
      RST_ST_RESET   = 2'b00,
      RST_ST_STRETCH = 2'b01,
      RST_ST_RUN     = 2'b10,
      RST_ST_SOFT    = 2'b11
   } rst_state_e;

   localparam int RST_SYNC_STAGES_DEF    = 2;
   localparam int RST_STRETCH_CYCLES_DEF = 16;

endpackage

// File: rtl/rst_sync_chain.sv
// Reset-release synchronizer: a shift chain of 1s, cleared asynchronously by rst_n.
module rst_sync_chain
   import rst_pkg::*;
#(
   parameter int STAGES = RST_SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [STAGES-1:0] chain
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign chain = chain_q;

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes rst_n release, stretches it, and drives
// async/sync reset outputs. Optional warm-reset handshake under `SOFT_RST_EN.
module rst_sequencer
   import rst_pkg::*;
#(
   parameter int SYNC_STAGES    = RST_SYNC_STAGES_DEF,
   parameter int STRETCH_CYCLES = RST_STRETCH_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef SOFT_RST_EN
   input  logic       sw_rst_req,
   output logic       sw_rst_ack,
`endif
   output logic       rst_out,
   output logic       rst_sync,
   output logic       ready,
   output logic [1:0] state
);

   localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rst_sequencer: SYNC_STAGES must be at least 2");
   end
   if (STRETCH_CYCLES < 1) begin : g_bad_stretch
      $error("rst_sequencer: STRETCH_CYCLES must be at least 1");
   end

   logic [SYNC_STAGES-1:0] chain;

   rst_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .chain (chain)
   );

   rst_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rst_out_q, rst_out_d;
   logic             rst_sync_q, rst_sync_d;
   logic             ready_q, ready_d;
   logic             cnt_done;
   logic             chain_full;

`ifdef SOFT_RST_EN
   logic ack_q, ack_d;
   logic blk_q, blk_d;
`endif

   assign cnt_done = (cnt_q == CNT_W'(STRETCH_CYCLES - 1));

   // The last stage loads 1 on the same edge that all earlier stages read 1,
   // so STRETCH is entered exactly when the last stage goes high.
   assign chain_full = &chain[SYNC_STAGES-2:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef SOFT_RST_EN
      ack_d = ack_q;
      blk_d = blk_q;
      // A request held through power-on must be dropped before it counts.
      if (!sw_rst_req) begin
         ack_d = 1'b0;
         blk_d = 1'b0;
      end else if (state_q == RST_ST_RESET || state_q == RST_ST_STRETCH) begin
         blk_d = 1'b1;
      end
`endif

      case (state_q)
         RST_ST_RESET: begin
            cnt_d = '0;
            if (chain_full) begin
               state_d = RST_ST_STRETCH;
            end
         end
         RST_ST_STRETCH: begin
            if (cnt_done) begin
               state_d = RST_ST_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RST_ST_RUN: begin
`ifdef SOFT_RST_EN
            if (sw_rst_req && !ack_q && !blk_q) begin
               state_d = RST_ST_SOFT;
               cnt_d   = '0;
            end
`endif
         end
`ifdef SOFT_RST_EN
         RST_ST_SOFT: begin
            if (cnt_done) begin
               state_d = RST_ST_RUN;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         default: begin
            state_d = RST_ST_RESET;
            cnt_d   = '0;
         end
      endcase

      // Final chain stage also gates release as a safety interlock.
      ready_d    = (state_d == RST_ST_RUN) && chain[SYNC_STAGES-1];
      rst_out_d  = !ready_d;
      rst_sync_d = rst_out_q || rst_out_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_ST_RESET;
         cnt_q      <= '0;
         rst_out_q  <= 1'b1;
         rst_sync_q <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rst_out_q  <= rst_out_d;
         rst_sync_q <= rst_sync_d;
         ready_q    <= ready_d;
      end
   end

`ifdef SOFT_RST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
         blk_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         blk_q <= blk_d;
      end
   end

   assign sw_rst_ack = ack_q;
`endif

   assign rst_out  = rst_out_q;
   assign rst_sync = rst_sync_q;
   assign ready    = ready_q;
   assign state    = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance plus a SYNC_STAGES=3,
// STRETCH_CYCLES=1 instance; warm-reset scenarios run when SOFT_RST_EN is defined.
module tb_rst_sequencer;

   logic       clk;
   logic       rst_n;
   logic       sw_rst_req;
   logic       sw_rst_req2;
   logic       sw_rst_ack;
   logic       sw_rst_ack2;
   logic       rst_out, rst_sync, ready;
   logic [1:0] state;
   logic       rst_out2, rst_sync2, ready2;
   logic [1:0] state2;

   int n_checks = 0;
   int n_fail   = 0;
   int ecnt     = 0;

   rst_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef SOFT_RST_EN
      .sw_rst_req (sw_rst_req),
      .sw_rst_ack (sw_rst_ack),
`endif
      .rst_out    (rst_out),
      .rst_sync   (rst_sync),
      .ready      (ready),
      .state      (state)
   );

   rst_sequencer #(
      .SYNC_STAGES    (3),
      .STRETCH_CYCLES (1)
   ) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef SOFT_RST_EN
      .sw_rst_req (sw_rst_req2),
      .sw_rst_ack (sw_rst_ack2),
`endif
      .rst_out    (rst_out2),
      .rst_sync   (rst_sync2),
      .ready      (ready2),
      .state      (state2)
   );

`ifndef SOFT_RST_EN
   assign sw_rst_ack  = 1'b0;
   assign sw_rst_ack2 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, ecnt, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic chk_in_reset(input string tag);
      chk({tag, "_rst_out"},  32'(rst_out),  32'd1);
      chk({tag, "_rst_sync"}, 32'(rst_sync), 32'd1);
      chk({tag, "_ready"},    32'(ready),    32'd0);
      chk({tag, "_state"},    32'(state),    32'd0);
      chk({tag, "_ack"},      32'(sw_rst_ack), 32'd0);
      chk({tag, "_state2"},   32'(state2),   32'd0);
      chk({tag, "_rst_out2"}, 32'(rst_out2), 32'd1);
   endtask

   // rst_n must have just risen, ahead of the next rising edge (edge 1).
   task automatic run_release(input string tag);
      ecnt = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         chk({tag, "_state"},    32'(state),    (e < 2) ? 32'd0 : (e < 18) ? 32'd1 : 32'd2);
         chk({tag, "_rst_out"},  32'(rst_out),  (e < 18) ? 32'd1 : 32'd0);
         chk({tag, "_rst_sync"}, 32'(rst_sync), (e < 19) ? 32'd1 : 32'd0);
         chk({tag, "_ready"},    32'(ready),    (e < 18) ? 32'd0 : 32'd1);
         chk({tag, "_state2"},   32'(state2),   (e < 3) ? 32'd0 : (e < 4) ? 32'd1 : 32'd2);
         chk({tag, "_rst_out2"}, 32'(rst_out2), (e < 4) ? 32'd1 : 32'd0);
         chk({tag, "_rst_sync2"},32'(rst_sync2),(e < 5) ? 32'd1 : 32'd0);
         chk({tag, "_ready2"},   32'(ready2),   (e < 4) ? 32'd0 : 32'd1);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      sw_rst_req  = 1'b0;
      sw_rst_req2 = 1'b0;
      #22;
      chk_in_reset("por_hold");

      // power-on release
      @(negedge clk);
      rst_n = 1'b1;
      run_release("por");

      // short rst_n glitch between edges in RUN
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_in_reset("glitch");
      #2;
      rst_n = 1'b1;
      run_release("glitch_rel");

      // rst_n drop in the 5th STRETCH cycle
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_in_reset("pre_abort");
      @(negedge clk);
      rst_n = 1'b1;
      ecnt = 0;
      repeat (6) tick();
      chk("abort_pre_state", 32'(state), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_in_reset("abort");
      #2;
      rst_n = 1'b1;
      run_release("abort_rel");

`ifdef SOFT_RST_EN
      // warm reset requested at edge 30
      while (ecnt < 29) tick();
      sw_rst_req = 1'b1;
      tick();
      chk("soft_state",    32'(state),    32'd3);
      chk("soft_rst_out",  32'(rst_out),  32'd1);
      chk("soft_rst_sync", 32'(rst_sync), 32'd1);
      chk("soft_ready",    32'(ready),    32'd0);
      chk("soft_ack0",     32'(sw_rst_ack), 32'd0);
      while (ecnt < 45) tick();
      chk("soft45_state",   32'(state),   32'd3);
      chk("soft45_rst_out", 32'(rst_out), 32'd1);
      tick();
      chk("soft46_state",    32'(state),      32'd2);
      chk("soft46_rst_out",  32'(rst_out),    32'd0);
      chk("soft46_ack",      32'(sw_rst_ack), 32'd1);
      chk("soft46_ready",    32'(ready),      32'd1);
      chk("soft46_rst_sync", 32'(rst_sync),   32'd1);
      tick();
      chk("soft47_rst_sync", 32'(rst_sync), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("soft_hold_state", 32'(state),      32'd2);
         chk("soft_hold_ack",   32'(sw_rst_ack), 32'd1);
         chk("soft_hold_rst",   32'(rst_out),    32'd0);
      end
      sw_rst_req = 1'b0;
      tick();
      chk("soft_ack_drop", 32'(sw_rst_ack), 32'd0);
      chk("soft_ack_drop_state", 32'(state), 32'd2);

      // request held through power-on must not start a warm reset
      @(negedge clk);
      sw_rst_req = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_in_reset("held_rst");
      @(negedge clk);
      rst_n = 1'b1;
      run_release("held_rel");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("held_state", 32'(state),      32'd2);
         chk("held_ack",   32'(sw_rst_ack), 32'd0);
      end
      sw_rst_req = 1'b0;
      tick();
      chk("rearm_state", 32'(state), 32'd2);
      sw_rst_req = 1'b1;
      tick();
      chk("rearm_soft_state",   32'(state),   32'd3);
      chk("rearm_soft_rst_out", 32'(rst_out), 32'd1);
      repeat (16) tick();
      chk("rearm_done_state", 32'(state),      32'd2);
      chk("rearm_done_ack",   32'(sw_rst_ack), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_in_reset("ack_clear");
      rst_n = 1'b1;
      sw_rst_req = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
